// File: rtl/key_gen_pkg.sv
// Shared types and constants for the bouncing key stimulus generator.
// State encoding, LFSR taps and default seed.
package key_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Galois form, shifting right: x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/key_lfsr16.sv
// 16-bit Galois LFSR that steps only when asked.
// Reset reloads the seed so bounce timing is reproducible.
module key_lfsr16
  import key_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= seed;
    end else if (adv) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/key_bounce_gen.sv
// Bouncing mechanical-key waveform source for debouncer stimulus.
// Takes press/release commands, bounces, holds, then pulses done.
module key_bounce_gen
  import key_gen_pkg::*;
#(
  parameter int          N_BOUNCES   = 5,
  parameter int          BOUNCE_W    = 8,
  parameter int          HOLD_CYCLES = 140000,
  parameter logic [15:0] LFSR_SEED   = DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_level,
  output logic cmd_ready,
  output logic key,
  output logic busy,
  output logic done
);

  localparam int TW = (N_BOUNCES > 0) ?
    $clog2(2 * N_BOUNCES + 1) : 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [TW-1:0] TOG_LOAD  = TW'(2 * N_BOUNCES);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TOG_ONE   = TW'(1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [BOUNCE_W-1:0] IVL_ONE = BOUNCE_W'(1);

  state_t state, state_n;

  logic                key_n;
  logic                done_n;
  logic                adv;
  logic [TW-1:0]       tog, tog_n;
  logic [BOUNCE_W-1:0] ivl, ivl_n;
  logic [HW-1:0]       hold, hold_n;
  logic [15:0]         lfsr;
  logic [BOUNCE_W-1:0] ivl_seed;
  logic                unused_lfsr;

  key_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (adv),
    .seed  (LFSR_SEED),
    .state (lfsr)
  );

  // forcing bit 0 keeps every interval odd and nonzero
  assign ivl_seed    = lfsr[BOUNCE_W-1:0] | IVL_ONE;
  assign unused_lfsr = ^lfsr;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_n = state;
    key_n   = key;
    tog_n   = tog;
    ivl_n   = ivl;
    hold_n  = hold;
    done_n  = 1'b0;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          key_n = cmd_level;
          if (N_BOUNCES > 0 && cmd_level != key) begin
            state_n = BOUNCE;
            tog_n   = TOG_LOAD;
            ivl_n   = ivl_seed;
            adv     = 1'b1;
          end else begin
            state_n = HOLD;
            hold_n  = HOLD_LOAD;
          end
        end
      end
      BOUNCE: begin
        if (ivl == IVL_ONE) begin
          key_n = ~key;
          tog_n = tog - TOG_ONE;
          ivl_n = ivl_seed;
          adv   = 1'b1;
          // even toggle count: key is back at the target
          if (tog == TOG_ONE) begin
            state_n = HOLD;
            hold_n  = HOLD_LOAD;
          end
        end else begin
          ivl_n = ivl - IVL_ONE;
        end
      end
      HOLD: begin
        if (hold == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          hold_n = hold - HOLD_ONE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      key   <= 1'b0;
      tog   <= '0;
      ivl   <= '0;
      hold  <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      key   <= key_n;
      tog   <= tog_n;
      ivl   <= ivl_n;
      hold  <= hold_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench for key_bounce_gen: three parameter sets,
// reference LFSR timing and a behavioural debouncer loopback.
module tb_key_bounce_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic v0, l0, r0, k0, b0, d0;
  logic v1, l1, r1, k1, b1, d1;
  logic v2, l2, r2, k2, b2, d2;

  key_bounce_gen #(
    .N_BOUNCES(0), .BOUNCE_W(8), .HOLD_CYCLES(4),
    .LFSR_SEED(16'hACE1)
  ) u0 (
    .clk(clk), .rst(rst), .cmd_valid(v0), .cmd_level(l0),
    .cmd_ready(r0), .key(k0), .busy(b0), .done(d0)
  );

  key_bounce_gen #(
    .N_BOUNCES(2), .BOUNCE_W(4), .HOLD_CYCLES(8),
    .LFSR_SEED(16'hACE1)
  ) u1 (
    .clk(clk), .rst(rst), .cmd_valid(v1), .cmd_level(l1),
    .cmd_ready(r1), .key(k1), .busy(b1), .done(d1)
  );

  key_bounce_gen #(
    .N_BOUNCES(3), .BOUNCE_W(2), .HOLD_CYCLES(16),
    .LFSR_SEED(16'hACE1)
  ) u2 (
    .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_level(l2),
    .cmd_ready(r2), .key(k2), .busy(b2), .done(d2)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    if (s[0]) return (s >> 1) ^ 16'hB400;
    return s >> 1;
  endfunction

  // debouncer with x=4: level qualifies after 8 stable samples
  logic db;
  int   stab, n_press, n_depress;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      db <= 1'b0; stab <= 0;
      n_press <= 0; n_depress <= 0;
    end else if (k2 != db) begin
      if (stab == 7) begin
        db <= k2; stab <= 0;
        if (k2) n_press <= n_press + 1;
        else n_depress <= n_depress + 1;
      end else begin
        stab <= stab + 1;
      end
    end else begin
      stab <= 0;
    end
  end

  typedef struct {
    logic       v;
    logic       l;
    logic [3:0] exp;  // {key, ready, busy, done}
  } vec_t;

  vec_t tbl[17];

  task automatic run_press1(input string tag);
    logic [15:0] s;
    int t[4];
    int acc, last, tg, nt;
    logic pk;
    logic [2:0] e;
    s = 16'hACE1;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      acc += int'(s[3:0] | 4'd1);
      t[i] = acc;
      s = ref_step(s);
    end
    last = t[3] + 8;
    v1 = 1'b1; l1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    chk({tag, " accept"}, {28'd0, k1, r1, b1, d1}, 32'b1010);
    tg = 0;
    pk = k1;
    for (int k = 1; k <= last; k++) begin
      nt = 0;
      for (int j = 0; j < 4; j++) if (t[j] <= k) nt++;
      @(posedge clk); #1;
      if (k1 != pk) tg++;
      pk = k1;
      e = {1'b1 ^ nt[0], k < last, k == last};
      chk($sformatf("%s cyc%0d", tag, k), {29'd0, k1, b1, d1},
          {29'd0, e});
    end
    chk({tag, " toggles"}, tg, 4);
    @(posedge clk); #1;
    chk({tag, " done width"}, {30'd0, d1, r1}, 32'b01);
  endtask

  initial begin
    int c, tg;
    logic pk;
    rst = 1'b0;
    v0 = 0; l0 = 0; v1 = 0; l1 = 0; v2 = 0; l2 = 0;

    tbl[0]  = '{1'b1, 1'b1, 4'b1010};
    tbl[1]  = '{1'b1, 1'b0, 4'b1010};
    tbl[2]  = '{1'b0, 1'b0, 4'b1010};
    tbl[3]  = '{1'b0, 1'b0, 4'b1010};
    tbl[4]  = '{1'b0, 1'b0, 4'b1101};
    tbl[5]  = '{1'b0, 1'b0, 4'b1100};
    tbl[6]  = '{1'b1, 1'b1, 4'b1010};
    tbl[7]  = '{1'b0, 1'b0, 4'b1010};
    tbl[8]  = '{1'b0, 1'b0, 4'b1010};
    tbl[9]  = '{1'b0, 1'b0, 4'b1010};
    tbl[10] = '{1'b0, 1'b0, 4'b1101};
    tbl[11] = '{1'b1, 1'b0, 4'b0010};
    tbl[12] = '{1'b0, 1'b0, 4'b0010};
    tbl[13] = '{1'b0, 1'b0, 4'b0010};
    tbl[14] = '{1'b0, 1'b0, 4'b0010};
    tbl[15] = '{1'b0, 1'b0, 4'b0101};
    tbl[16] = '{1'b0, 1'b0, 4'b0100};

    // asynchronous reset, asserted mid-cycle
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst u0", {28'd0, k0, r0, b0, d0}, 32'b0100);
    chk("rst u1", {28'd0, k1, r1, b1, d1}, 32'b0100);
    chk("rst u2", {28'd0, k2, r2, b2, d2}, 32'b0100);
    #3 rst = 1'b0;

    // clean press, ignored command, redundant press, release
    for (int i = 0; i < 17; i++) begin
      v0 = tbl[i].v;
      l0 = tbl[i].l;
      @(posedge clk); #1;
      chk($sformatf("u0 vec%0d", i), {28'd0, k0, r0, b0, d0},
          {28'd0, tbl[i].exp});
    end
    v0 = 1'b0;

    // bouncing press against the reference LFSR
    run_press1("bounce");

    // reset after the second toggle, then replay
    #3 rst = 1'b1;
    #1;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    v1 = 1'b1; l1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0;
    tg = 0;
    pk = k1;
    for (c = 0; c < 50 && tg < 2; c++) begin
      @(posedge clk); #1;
      if (k1 != pk) tg++;
      pk = k1;
    end
    chk("midrst two toggles", tg, 2);
    #3 rst = 1'b1;
    #1;
    chk("midrst async", {28'd0, k1, r1, b1, d1}, 32'b0100);
    #3 rst = 1'b0;
    tg = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (d1) tg++;
    end
    chk("midrst no done", tg, 0);
    run_press1("replay");

    // loopback through the debouncer model
    v2 = 1'b1; l2 = 1'b1;
    @(posedge clk); #1;
    v2 = 1'b0;
    for (c = 0; c < 200 && d2 !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    chk("loop press done", {31'd0, d2}, 1);
    chk("loop press key", {31'd0, k2}, 1);
    chk("loop press count", n_press, 1);
    chk("loop depress early", n_depress, 0);
    @(posedge clk); #1;
    v2 = 1'b1; l2 = 1'b0;
    @(posedge clk); #1;
    v2 = 1'b0;
    for (c = 0; c < 200 && d2 !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    chk("loop release done", {31'd0, d2}, 1);
    chk("loop release key", {31'd0, k2}, 0);
    chk("loop depress count", n_depress, 1);
    chk("loop press stable", n_press, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
